// File: rtl/pipe_pkg.sv
// Shared types for the EXE->MEM pipeline register.
// Holds the state encoding, payload layout and default widths.
package pipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEST_W_DEF = 4;
    localparam int CTL_W = 3;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    typedef struct packed {
        logic                  wb_en;
        logic                  mem_r_en;
        logic                  mem_w_en;
        logic [DEST_W_DEF-1:0] dest;
        logic [DATA_W_DEF-1:0] alu_res;
        logic [DATA_W_DEF-1:0] val_rm;
    } exe_mem_payload_t;

    function automatic int payload_w(int data_w, int dest_w);
        return CTL_W + dest_w + 2 * data_w;
    endfunction

endpackage

// File: rtl/skid_entry.sv
// One buffered payload slot with a valid bit.
// kill drops the slot and zeroes its control bits; data is kept.
module skid_entry
    import pipe_pkg::*;
#(
    parameter int W = payload_w(DATA_W_DEF, DEST_W_DEF)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         kill,
    input  logic         pop,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         valid
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q     <= '0;
            valid <= 1'b0;
        end else if (kill) begin
            valid           <= 1'b0;
            q[W-1 -: CTL_W] <= '0;
        end else if (load) begin
            q     <= d;
            valid <= 1'b1;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/exe_mem_skid_reg.sv
// EXE->MEM pipeline register with a two-entry skid buffer.
// in_ready depends only on held entries, never on out_ready.
module exe_mem_skid_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEST_W = DEST_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic [DEST_W-1:0] dest_in,
    input  logic [DATA_W-1:0] alu_res_in,
    input  logic [DATA_W-1:0] val_rm_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              wb_en_out,
    output logic              mem_r_en_out,
    output logic              mem_w_en_out,
    output logic [DEST_W-1:0] dest_out,
    output logic [DATA_W-1:0] alu_res_out,
    output logic [DATA_W-1:0] val_rm_out,
    output logic [1:0]        count
);

    typedef struct packed {
        logic              wb_en;
        logic              mem_r_en;
        logic              mem_w_en;
        logic [DEST_W-1:0] dest;
        logic [DATA_W-1:0] alu_res;
        logic [DATA_W-1:0] val_rm;
    } payload_t;

    localparam int PW = $bits(payload_t);

    payload_t in_p;
    payload_t main_d;
    payload_t main_q;
    payload_t skid_q;
    logic     main_v;
    logic     skid_v;
    state_e   state;
    logic     accept;
    logic     consume;
    logic     main_load;
    logic     main_from_skid;
    logic     main_pop;
    logic     skid_load;
    logic     skid_pop;

    assign in_p = '{
        wb_en:    wb_en_in,
        mem_r_en: mem_r_en_in,
        mem_w_en: mem_w_en_in,
        dest:     dest_in,
        alu_res:  alu_res_in,
        val_rm:   val_rm_in
    };

    // SKID only fills behind MAIN, so the two valid bits are the state
    always_comb begin
        state = EMPTY;
        if (skid_v)
            state = FULL;
        else if (main_v)
            state = ONE;
    end

    assign in_ready = (state != FULL);
    assign accept   = in_valid & in_ready;
    assign consume  = main_v & out_ready;

    always_comb begin
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        main_pop       = 1'b0;
        skid_load      = 1'b0;
        skid_pop       = 1'b0;
        if (!flush) begin
            unique case (state)
                EMPTY: main_load = accept;
                ONE: begin
                    if (accept)
                        main_load = consume;
                    skid_load = accept & ~consume;
                    main_pop  = consume & ~accept;
                end
                FULL: begin
                    main_load      = consume;
                    main_from_skid = consume;
                    skid_pop       = consume;
                end
                default: ;
            endcase
        end
    end

    assign main_d = main_from_skid ? skid_q : in_p;

    skid_entry #(.W(PW)) u_main (
        .clk   (clk),
        .rst   (rst),
        .load  (main_load),
        .kill  (flush),
        .pop   (main_pop),
        .d     (main_d),
        .q     (main_q),
        .valid (main_v)
    );

    skid_entry #(.W(PW)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .kill  (flush),
        .pop   (skid_pop),
        .d     (in_p),
        .q     (skid_q),
        .valid (skid_v)
    );

    assign out_valid    = main_v;
    assign wb_en_out    = main_q.wb_en & main_v;
    assign mem_r_en_out = main_q.mem_r_en & main_v;
    assign mem_w_en_out = main_q.mem_w_en & main_v;
    assign dest_out     = main_q.dest;
    assign alu_res_out  = main_q.alu_res;
    assign val_rm_out   = main_q.val_rm;
    assign count        = state;

endmodule

// File: tb/tb_exe_mem_skid_reg.sv
// Bench for exe_mem_skid_reg: default and 64/5-bit instances
// share stimulus; a queue scoreboard checks every consumed entry.
module tb_exe_mem_skid_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic        wb_en_in;
    logic        mem_r_en_in;
    logic        mem_w_en_in;
    logic [4:0]  dest_in;
    logic [63:0] alu_res_in;
    logic [63:0] val_rm_in;

    logic        n_in_ready, n_out_valid;
    logic        n_wb, n_mr, n_mw;
    logic [3:0]  n_dest;
    logic [31:0] n_alu, n_val;
    logic [1:0]  n_count;

    logic        w_in_ready, w_out_valid;
    logic        w_wb, w_mr, w_mw;
    logic [4:0]  w_dest;
    logic [63:0] w_alu, w_val;
    logic [1:0]  w_count;

    typedef struct packed {
        logic        wb;
        logic        mr;
        logic        mw;
        logic [4:0]  dest;
        logic [63:0] alu;
        logic [63:0] val;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    exe_mem_skid_reg u_n (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (n_in_ready),
        .wb_en_in     (wb_en_in),
        .mem_r_en_in  (mem_r_en_in),
        .mem_w_en_in  (mem_w_en_in),
        .dest_in      (dest_in[3:0]),
        .alu_res_in   (alu_res_in[31:0]),
        .val_rm_in    (val_rm_in[31:0]),
        .out_valid    (n_out_valid),
        .out_ready    (out_ready),
        .wb_en_out    (n_wb),
        .mem_r_en_out (n_mr),
        .mem_w_en_out (n_mw),
        .dest_out     (n_dest),
        .alu_res_out  (n_alu),
        .val_rm_out   (n_val),
        .count        (n_count)
    );

    exe_mem_skid_reg #(.DATA_W(64), .DEST_W(5)) u_w (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (w_in_ready),
        .wb_en_in     (wb_en_in),
        .mem_r_en_in  (mem_r_en_in),
        .mem_w_en_in  (mem_w_en_in),
        .dest_in      (dest_in),
        .alu_res_in   (alu_res_in),
        .val_rm_in    (val_rm_in),
        .out_valid    (w_out_valid),
        .out_ready    (out_ready),
        .wb_en_out    (w_wb),
        .mem_r_en_out (w_mr),
        .mem_w_en_out (w_mw),
        .dest_out     (w_dest),
        .alu_res_out  (w_alu),
        .val_rm_out   (w_val),
        .count        (w_count)
    );

    task automatic chk(string tag, logic [63:0] obs,
                       logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h",
                   tag, obs, exp);
        end
    endtask

    task automatic check_state(string tag, int cnt,
                               logic ov, logic ir);
        chk({tag, ":n_count"}, 64'(n_count), 64'(cnt));
        chk({tag, ":w_count"}, 64'(w_count), 64'(cnt));
        chk({tag, ":n_out_valid"}, 64'(n_out_valid), 64'(ov));
        chk({tag, ":w_out_valid"}, 64'(w_out_valid), 64'(ov));
        chk({tag, ":n_in_ready"}, 64'(n_in_ready), 64'(ir));
        chk({tag, ":w_in_ready"}, 64'(w_in_ready), 64'(ir));
    endtask

    task automatic check_zero(string tag);
        chk({tag, ":w_ctl"}, 64'({w_wb, w_mr, w_mw}), 64'd0);
        chk({tag, ":n_ctl"}, 64'({n_wb, n_mr, n_mw}), 64'd0);
        chk({tag, ":w_dest"}, 64'(w_dest), 64'd0);
        chk({tag, ":n_dest"}, 64'(n_dest), 64'd0);
        chk({tag, ":w_alu"}, w_alu, 64'd0);
        chk({tag, ":n_alu"}, 64'(n_alu), 64'd0);
        chk({tag, ":w_val"}, w_val, 64'd0);
        chk({tag, ":n_val"}, 64'(n_val), 64'd0);
    endtask

    task automatic drive(logic v, logic [63:0] alu,
                         logic [4:0] dest, logic wb,
                         logic mr, logic mw);
        in_valid    = v;
        alu_res_in  = alu;
        val_rm_in   = ~alu;
        dest_in     = dest;
        wb_en_in    = wb;
        mem_r_en_in = mr;
        mem_w_en_in = mw;
    endtask

    // Called just after a falling edge with inputs settled
    task automatic tick();
        exp_t e;
        if (w_out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_out", 64'(w_out_valid), 64'd0);
            end else begin
                e = q.pop_front();
                chk("sb:w_alu", w_alu, e.alu);
                chk("sb:w_val", w_val, e.val);
                chk("sb:w_dest", 64'(w_dest), 64'(e.dest));
                chk("sb:w_ctl", 64'({w_wb, w_mr, w_mw}),
                    64'({e.wb, e.mr, e.mw}));
                chk("sb:n_valid", 64'(n_out_valid), 64'd1);
                chk("sb:n_alu", 64'(n_alu), 64'(e.alu[31:0]));
                chk("sb:n_dest", 64'(n_dest), 64'(e.dest[3:0]));
                chk("sb:n_ctl", 64'({n_wb, n_mr, n_mw}),
                    64'({e.wb, e.mr, e.mw}));
            end
        end
        if (flush) begin
            q.delete();
        end else if (in_valid && w_in_ready) begin
            e = '{wb: wb_en_in, mr: mem_r_en_in,
                  mw: mem_w_en_in, dest: dest_in,
                  alu: alu_res_in, val: val_rm_in};
            q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check_state("reset", 0, 1'b0, 1'b1);
        check_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        out_ready = 1'b1;
        drive(1'b1, 64'h10, 5'd1, 1'b1, 1'b0, 1'b0);
        tick();
        check_state("s1", 1, 1'b1, 1'b1);
        drive(1'b1, 64'h11, 5'd2, 1'b0, 1'b1, 1'b0);
        tick();
        check_state("s2", 1, 1'b1, 1'b1);
        drive(1'b1, 64'h12, 5'd3, 1'b0, 1'b0, 1'b1);
        tick();
        check_state("s3", 1, 1'b1, 1'b1);
        drive(1'b0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        check_state("s_end", 0, 1'b0, 1'b1);

        out_ready = 1'b0;
        drive(1'b1, 64'hFFFF_FFFF_0000_0001, 5'd31,
              1'b1, 1'b0, 1'b1);
        tick();
        check_state("bp1", 1, 1'b1, 1'b1);
        drive(1'b1, 64'hA1, 5'd7, 1'b0, 1'b1, 1'b0);
        tick();
        check_state("bp_full", 2, 1'b1, 1'b0);
        drive(1'b1, 64'hA2, 5'd8, 1'b1, 1'b1, 1'b1);
        tick();
        check_state("bp_hold", 2, 1'b1, 1'b0);
        out_ready = 1'b1;
        drive(1'b0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        check_state("bp_drain1", 1, 1'b1, 1'b1);
        tick();
        check_state("bp_drain2", 0, 1'b0, 1'b1);

        out_ready = 1'b0;
        drive(1'b1, 64'hB0, 5'd4, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b1, 64'hB1, 5'd5, 1'b1, 1'b0, 1'b1);
        tick();
        check_state("fl_full", 2, 1'b1, 1'b0);
        chk("fl_pre:w_mw", 64'(w_mw), 64'd1);
        flush = 1'b1;
        drive(1'b1, 64'hBF, 5'd6, 1'b1, 1'b1, 1'b1);
        tick();
        flush = 1'b0;
        drive(1'b0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        check_state("flush", 0, 1'b0, 1'b1);
        chk("flush:w_mw", 64'(w_mw), 64'd0);
        chk("flush:n_mw", 64'(n_mw), 64'd0);
        chk("flush:w_wb", 64'(w_wb), 64'd0);
        chk("flush:w_alu_held", w_alu, 64'hB0);
        chk("flush:n_alu_held", 64'(n_alu), 64'hB0);
        out_ready = 1'b1;
        tick();
        tick();
        check_state("post_flush", 0, 1'b0, 1'b1);

        out_ready = 1'b0;
        drive(1'b1, 64'hC0, 5'd10, 1'b1, 1'b1, 1'b1);
        tick();
        drive(1'b1, 64'hC1, 5'd11, 1'b1, 1'b1, 1'b1);
        tick();
        drive(1'b0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        check_state("ar_full", 2, 1'b1, 1'b0);
        #2 rst = 1'b0;
        #1;
        check_state("async", 0, 1'b0, 1'b1);
        check_zero("async");
        q.delete();
        @(negedge clk);
        rst       = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 64'hD0, 5'd9, 1'b0, 1'b1, 1'b0);
        tick();
        check_state("ar_resume", 1, 1'b1, 1'b1);
        drive(1'b0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        check_state("ar_done", 0, 1'b0, 1'b1);
        chk("sb_empty", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
